// File: rtl/noc_pkg.sv
// Shared helpers for the round-robin NoC router: header slicing and
// round-robin index stepping.
package noc_pkg;

    // Width of the destination field needed to name NPORT channels.
    function automatic int calc_pw(input int nport);
        return (nport <= 2) ? 1 : $clog2(nport);
    endfunction

    // The destination field sits in the topmost bits of the flit.
    function automatic int dest_msb(input int wd);
        return wd - 1;
    endfunction

    // Next index in a wrapping 0..n-1 priority ring.
    function automatic int rr_next(input int cur, input int n);
        return (cur + 1 >= n) ? 0 : cur + 1;
    endfunction

endpackage

// File: rtl/router_fifo.sv
// Per-input synchronous FIFO: registered count drives full/empty and the
// head entry is visible combinationally.
module router_fifo #(
    parameter  int WD    = 40,
    parameter  int DEPTH = 4,
    localparam int AW    = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          wr_en,
    input  logic [WD-1:0] wr_data,
    input  logic          rd_en,
    output logic [WD-1:0] head,
    output logic          full,
    output logic          empty
);

    logic [WD-1:0] mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic [AW:0]   count;
    logic          push;
    logic          pop;

    assign full  = (count == (AW+1)'(DEPTH));
    assign empty = (count == '0);
    assign head  = mem[rd_ptr];

    // A write that arrives while full is dropped even if a pop frees a slot
    // on the same edge.
    assign push = wr_en && !full;
    assign pop  = rd_en && !empty;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr] <= wr_data;
    end

endmodule

// File: rtl/noc_router_rr.sv
// NPORT x NPORT single-flit router: input FIFOs, per-output round-robin
// arbitration with downstream backpressure, and illegal-destination drops.
module noc_router_rr
    import noc_pkg::*;
#(
    parameter int WD    = 40,
    parameter int NPORT = 3,
    parameter int DEPTH = 4,
    parameter int PW    = calc_pw(NPORT)
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic [NPORT-1:0]    in_wr_en,
    input  logic [NPORT*WD-1:0] in_data,
    output logic [NPORT-1:0]    in_full,
    output logic [NPORT-1:0]    out_wr_en,
    output logic [NPORT*WD-1:0] out_data,
    input  logic [NPORT-1:0]    out_next_full,
    output logic [NPORT-1:0]    drop_err
);

    localparam int DEST_MSB = dest_msb(WD);

    logic [WD-1:0]    head     [NPORT];
    logic [PW-1:0]    dest     [NPORT];
    logic [NPORT-1:0] empty;
    logic [NPORT-1:0] legal;
    logic [NPORT-1:0] drop_now;
    logic [NPORT-1:0] pop;

    logic [NPORT-1:0] req      [NPORT];
    logic [NPORT-1:0] grant    [NPORT];
    logic [NPORT-1:0] gnt_any;
    logic [PW-1:0]    gnt_idx  [NPORT];
    logic [PW-1:0]    ptr      [NPORT];

    for (genvar i = 0; i < NPORT; i++) begin : g_in
        router_fifo #(
            .WD    (WD),
            .DEPTH (DEPTH)
        ) u_fifo (
            .clk     (clk),
            .rst_n   (rst_n),
            .wr_en   (in_wr_en[i]),
            .wr_data (in_data[i*WD +: WD]),
            .rd_en   (pop[i]),
            .head    (head[i]),
            .full    (in_full[i]),
            .empty   (empty[i])
        );

        assign dest[i]     = head[i][DEST_MSB -: PW];
        assign legal[i]    = (int'(dest[i]) < NPORT);
        assign drop_now[i] = !empty[i] && !legal[i];
    end

    // Each input has one head, so it requests at most one output per cycle.
    for (genvar j = 0; j < NPORT; j++) begin : g_req
        for (genvar i = 0; i < NPORT; i++) begin : g_src
            assign req[j][i] = !empty[i] && legal[i] && (int'(dest[i]) == j);
        end
    end

    // Search starts just after the last winner and wraps around the ring.
    always_comb begin
        logic [PW-1:0] idx;
        for (int j = 0; j < NPORT; j++) begin
            grant[j]   = '0;
            gnt_any[j] = 1'b0;
            gnt_idx[j] = '0;
            idx        = PW'(rr_next(int'(ptr[j]), NPORT));
            for (int k = 0; k < NPORT; k++) begin
                if (!out_next_full[j] && !gnt_any[j] && req[j][idx]) begin
                    grant[j][idx] = 1'b1;
                    gnt_any[j]    = 1'b1;
                    gnt_idx[j]    = idx;
                end
                idx = PW'(rr_next(int'(idx), NPORT));
            end
        end
    end

    always_comb begin
        pop = drop_now;
        for (int j = 0; j < NPORT; j++) begin
            pop = pop | grant[j];
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int j = 0; j < NPORT; j++) begin
                ptr[j] <= PW'(NPORT - 1);
            end
            out_wr_en <= '0;
            out_data  <= '0;
            drop_err  <= '0;
        end else begin
            drop_err <= drop_now;
            for (int j = 0; j < NPORT; j++) begin
                out_wr_en[j] <= gnt_any[j];
                if (gnt_any[j]) begin
                    ptr[j]                <= gnt_idx[j];
                    out_data[j*WD +: WD]  <= head[gnt_idx[j]];
                end
            end
        end
    end

endmodule

// File: tb/tb_noc_router_rr.sv
// Directed bench for noc_router_rr: reset, routing, contention, backpressure,
// illegal-destination drops and full-FIFO write behaviour.
module tb_noc_router_rr;

    localparam int WD    = 40;
    localparam int NPORT = 3;
    localparam int DEPTH = 4;

    logic                clk;
    logic                rst_n;
    logic [NPORT-1:0]    in_wr_en;
    logic [NPORT*WD-1:0] in_data;
    logic [NPORT-1:0]    in_full;
    logic [NPORT-1:0]    out_wr_en;
    logic [NPORT*WD-1:0] out_data;
    logic [NPORT-1:0]    out_next_full;
    logic [NPORT-1:0]    drop_err;

    int n_checks;
    int n_fail;
    logic [WD-1:0] exp_q[$];

    noc_router_rr #(
        .WD    (WD),
        .NPORT (NPORT),
        .DEPTH (DEPTH)
    ) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .in_wr_en      (in_wr_en),
        .in_data       (in_data),
        .in_full       (in_full),
        .out_wr_en     (out_wr_en),
        .out_data      (out_data),
        .out_next_full (out_next_full),
        .drop_err      (drop_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        bit stale;
        rst_n = 1'b0;
        in_wr_en = '0;
        in_data = '0;
        out_next_full = '0;
        #12;
        n_checks++;
        if ({in_full, out_wr_en, drop_err} !== '0 || out_data !== '0) begin
            n_fail++;
            $display("FAIL reset_hold: in_full=%b out_wr_en=%b drop_err=%b out_data=%h, required all zero",
                     in_full, out_wr_en, drop_err, out_data);
        end
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        tick();
        // Queue three dest-0 flits on input 0 so traffic is flowing.
        in_wr_en = 3'b001;
        in_data[0 +: WD] = 40'h00_0000_00A1;
        tick();
        in_data[0 +: WD] = 40'h00_0000_00A2;
        tick();
        in_data[0 +: WD] = 40'h00_0000_00A3;
        tick();
        in_wr_en = '0;
        n_checks++;
        if (out_wr_en !== 3'b001) begin
            n_fail++;
            $display("FAIL reset_pre_active: out_wr_en=%b, required 001", out_wr_en);
        end
        #2;
        rst_n = 1'b0;
        #1;
        n_checks++;
        if ({in_full, out_wr_en, drop_err} !== '0 || out_data !== '0) begin
            n_fail++;
            $display("FAIL reset_async: in_full=%b out_wr_en=%b drop_err=%b out_data=%h, required all zero",
                     in_full, out_wr_en, drop_err, out_data);
        end
        tick();
        rst_n = 1'b1;
        stale = 1'b0;
        for (int c = 0; c < 5; c++) begin
            tick();
            if (out_wr_en !== '0 || drop_err !== '0) stale = 1'b1;
        end
        n_checks++;
        if (stale) begin
            n_fail++;
            $display("FAIL reset_no_stale: saw out_wr_en/drop_err activity after reset, required none");
        end
    endtask

    task automatic test_single_flit();
        in_wr_en = 3'b001;
        in_data[0 +: WD] = 40'h40_0000_0001;
        tick();
        in_wr_en = '0;
        n_checks++;
        if (out_wr_en !== 3'b000) begin
            n_fail++;
            $display("FAIL single_early: out_wr_en=%b, required 000", out_wr_en);
        end
        tick();
        n_checks++;
        if (out_wr_en !== 3'b010) begin
            n_fail++;
            $display("FAIL single_strobe: out_wr_en=%b, required 010", out_wr_en);
        end
        n_checks++;
        if (out_data[WD +: WD] !== 40'h40_0000_0001) begin
            n_fail++;
            $display("FAIL single_data: out_data[1]=%h, required 4000000001", out_data[WD +: WD]);
        end
        tick();
        n_checks++;
        if (out_wr_en !== 3'b000) begin
            n_fail++;
            $display("FAIL single_after: out_wr_en=%b, required 000", out_wr_en);
        end
    endtask

    task automatic test_contention();
        logic [WD-1:0] exp;
        for (int round = 0; round < 2; round++) begin
            in_wr_en = 3'b111;
            in_data[0*WD +: WD] = 40'h80_0000_0000;
            in_data[1*WD +: WD] = 40'h80_0000_0001;
            in_data[2*WD +: WD] = 40'h80_0000_0002;
            tick();
            in_wr_en = '0;
            for (int r = 0; r < 3; r++) begin
                tick();
                exp = 40'h80_0000_0000 + 40'(r);
                n_checks++;
                if (out_wr_en !== 3'b100 || out_data[2*WD +: WD] !== exp) begin
                    n_fail++;
                    $display("FAIL contention_r%0d_s%0d: out_wr_en=%b out_data[2]=%h, required 100 / %h",
                             round, r, out_wr_en, out_data[2*WD +: WD], exp);
                end
            end
            tick();
            n_checks++;
            if (out_wr_en !== 3'b000) begin
                n_fail++;
                $display("FAIL contention_idle_r%0d: out_wr_en=%b, required 000", round, out_wr_en);
            end
        end
    endtask

    task automatic test_backpressure();
        logic [WD-1:0] exp;
        out_next_full = 3'b010;
        in_wr_en = 3'b001;
        for (int n = 0; n < 5; n++) begin
            in_data[0 +: WD] = 40'h40_0000_0010 + 40'(n);
            tick();
        end
        in_wr_en = '0;
        n_checks++;
        if (in_full[0] !== 1'b1) begin
            n_fail++;
            $display("FAIL bp_full: in_full[0]=%b, required 1", in_full[0]);
        end
        n_checks++;
        if (out_wr_en !== 3'b000) begin
            n_fail++;
            $display("FAIL bp_blocked: out_wr_en=%b, required 000", out_wr_en);
        end
        out_next_full = '0;
        for (int n = 0; n < 4; n++) begin
            tick();
            exp = 40'h40_0000_0010 + 40'(n);
            n_checks++;
            if (out_wr_en !== 3'b010 || out_data[WD +: WD] !== exp) begin
                n_fail++;
                $display("FAIL bp_drain_%0d: out_wr_en=%b out_data[1]=%h, required 010 / %h",
                         n, out_wr_en, out_data[WD +: WD], exp);
            end
        end
        n_checks++;
        if (in_full[0] !== 1'b0) begin
            n_fail++;
            $display("FAIL bp_not_full: in_full[0]=%b, required 0", in_full[0]);
        end
        tick();
        n_checks++;
        if (out_wr_en !== 3'b000) begin
            n_fail++;
            $display("FAIL bp_fifth_rejected: out_wr_en=%b out_data[1]=%h, required 000",
                     out_wr_en, out_data[WD +: WD]);
        end
    endtask

    task automatic test_illegal_dest();
        in_wr_en = 3'b100;
        in_data[2*WD +: WD] = 40'hC0_0000_0005;
        tick();
        in_wr_en = '0;
        n_checks++;
        if (drop_err !== 3'b000) begin
            n_fail++;
            $display("FAIL drop_early: drop_err=%b, required 000", drop_err);
        end
        tick();
        n_checks++;
        if (drop_err !== 3'b100 || out_wr_en !== 3'b000) begin
            n_fail++;
            $display("FAIL drop_pulse: drop_err=%b out_wr_en=%b, required 100 / 000", drop_err, out_wr_en);
        end
        tick();
        n_checks++;
        if (drop_err !== 3'b000 || out_wr_en !== 3'b000) begin
            n_fail++;
            $display("FAIL drop_one_cycle: drop_err=%b out_wr_en=%b, required 000 / 000", drop_err, out_wr_en);
        end
        in_wr_en = 3'b100;
        in_data[2*WD +: WD] = 40'h00_0000_0007;
        tick();
        in_wr_en = '0;
        tick();
        n_checks++;
        if (out_wr_en !== 3'b001 || out_data[0 +: WD] !== 40'h00_0000_0007 || drop_err !== 3'b000) begin
            n_fail++;
            $display("FAIL drop_then_legal: out_wr_en=%b out_data[0]=%h drop_err=%b, required 001 / 0000000007 / 000",
                     out_wr_en, out_data[0 +: WD], drop_err);
        end
    endtask

    task automatic test_full_with_pop();
        int acc;
        int del;
        logic [WD-1:0] exp;
        acc = 0;
        del = 0;
        exp_q.delete();
        out_next_full = 3'b001;
        in_wr_en = 3'b010;
        for (int c = 0; c < 22; c++) begin
            if (c == 6)  out_next_full = '0;
            if (c == 16) in_wr_en = '0;
            in_data[WD +: WD] = 40'h00_0000_0100 + 40'(c);
            if (in_wr_en[1] && !in_full[1]) begin
                exp_q.push_back(in_data[WD +: WD]);
                acc++;
            end
            tick();
            if (c == 3) begin
                n_checks++;
                if (in_full[1] !== 1'b1) begin
                    n_fail++;
                    $display("FAIL fp_filled: in_full[1]=%b, required 1", in_full[1]);
                end
            end
            if (out_wr_en[0] === 1'b1) begin
                del++;
                exp = (exp_q.size() > 0) ? exp_q.pop_front() : 'x;
                n_checks++;
                if (out_data[0 +: WD] !== exp) begin
                    n_fail++;
                    $display("FAIL fp_data_%0d: out_data[0]=%h, required %h", del, out_data[0 +: WD], exp);
                end
            end
        end
        n_checks++;
        if (acc !== 13 || del !== 13) begin
            n_fail++;
            $display("FAIL fp_counts: accepted=%0d delivered=%0d, required 13 / 13", acc, del);
        end
        n_checks++;
        if (in_full[1] !== 1'b0) begin
            n_fail++;
            $display("FAIL fp_end_empty: in_full[1]=%b, required 0", in_full[1]);
        end
    endtask

    initial begin
        n_checks = 0;
        n_fail = 0;
        test_reset();
        test_single_flit();
        test_contention();
        test_backpressure();
        test_illegal_dest();
        test_full_with_pop();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
